exe_stage: RTL

Execute stage of the 5-stage MIPS pipeline. Consumes the decoded operands and control held in the decode-to-execute pipeline register, applies forwarding, computes the ALU result, destination register and store data for the execute-to-memory register, and contains an iterative multiply/divide unit with HI/LO registers. When a multiply/divide is in progress, the block raises a stall so the hazard logic freezes the upstream stages.

---
 rtl/exe_stage.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/exe_stage.sv
// MIPS execute stage: forwarding muxes, combinational ALU, and an iterative
// multiply/divide unit (shift-add multiply, restoring divide) with HI/LO registers.
module exe_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             regwrite_exe,
    input  logic             memtoreg_exe,
    input  logic             memwrite_exe,
    input  logic             alusrc_exe,
    input  logic             regdst_exe,
    input  logic [3:0]       alucontrol_exe,
    input  logic [WIDTH-1:0] data1_exe,
    input  logic [WIDTH-1:0] data2_exe,
    input  logic [4:0]       Rs_exe,
    input  logic [4:0]       Rt_exe,
    input  logic [4:0]       Rd_exe,
    input  logic [WIDTH-1:0] signext_exe,
    input  logic [WIDTH-1:0] shamt_exe,
    input  logic [1:0]       forwardA_exe,
    input  logic [1:0]       forwardB_exe,
    input  logic [WIDTH-1:0] aluout_mem,
    input  logic [WIDTH-1:0] result_wb,
    output logic             regwrite_out,
    output logic             memtoreg_out,
    output logic             memwrite_out,
    output logic [WIDTH-1:0] aluout_exe,
    output logic [WIDTH-1:0] writedata_exe,
    output logic [4:0]       writereg_exe,
    output logic             stall_md
);

    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_XOR   = 4'b0011;
    localparam logic [3:0] OP_NOR   = 4'b0100;
    localparam logic [3:0] OP_SLL   = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_SRL   = 4'b1000;
    localparam logic [3:0] OP_SRA   = 4'b1001;
    localparam logic [3:0] OP_MULT  = 4'b1010;
    localparam logic [3:0] OP_MULTU = 4'b1011;
    localparam logic [3:0] OP_DIV   = 4'b1100;
    localparam logic [3:0] OP_DIVU  = 4'b1101;
    localparam logic [3:0] OP_MFHI  = 4'b1110;
    localparam logic [3:0] OP_MFLO  = 4'b1111;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    // ---------------- forwarding ----------------
    logic [WIDTH-1:0] fwd_raw [2];
    logic [WIDTH-1:0] fwd_val [2];
    logic [1:0]       fwd_sel [2];

    assign fwd_raw[0] = data1_exe;
    assign fwd_raw[1] = data2_exe;
    assign fwd_sel[0] = forwardA_exe;
    assign fwd_sel[1] = forwardB_exe;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            assign fwd_val[gi] = (fwd_sel[gi] == 2'b01) ? result_wb  :
                                 (fwd_sel[gi] == 2'b10) ? aluout_mem : fwd_raw[gi];
        end
    endgenerate

    logic [WIDTH-1:0] src_a, fwd_b, src_b;
    logic [4:0]       sh;

    assign src_a = fwd_val[0];
    assign fwd_b = fwd_val[1];
    assign src_b = alusrc_exe ? signext_exe : fwd_b;
    assign sh    = shamt_exe[4:0];

    // Register-number Rs and upper shamt bits belong to the hazard unit / decoder.
    logic unused_inputs;
    assign unused_inputs = ^{shamt_exe[WIDTH-1:5], Rs_exe};

    // ---------------- multiply/divide state ----------------
    state_t             state_reg, state_next;
    logic [CW-1:0]      count_reg, count_next;
    logic [2*WIDTH-1:0] work_reg, work_next;
    logic [WIDTH-1:0]   bmag_reg, bmag_next;
    logic               is_div_reg, is_div_next;
    logic               neg_q_reg, neg_q_next;
    logic               neg_r_reg, neg_r_next;
    logic               div_zero_reg, div_zero_next;
    logic [WIDTH-1:0]   hi_reg, hi_next;
    logic [WIDTH-1:0]   lo_reg, lo_next;

    logic is_md;
    assign is_md = (alucontrol_exe >= OP_MULT) && (alucontrol_exe <= OP_DIVU);

    // Operand magnitudes at issue; signedness only for MULT and DIV.
    logic             op_signed, sign_a, sign_b;
    logic [WIDTH-1:0] amag, bmag;

    assign op_signed = (alucontrol_exe == OP_MULT) || (alucontrol_exe == OP_DIV);
    assign sign_a    = op_signed & src_a[WIDTH-1];
    assign sign_b    = op_signed & src_b[WIDTH-1];
    assign amag      = sign_a ? -src_a : src_a;
    assign bmag      = sign_b ? -src_b : src_b;

    // One iteration: work_reg holds {accumulator/remainder, multiplier/quotient}.
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift, div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] mul_step, div_step, work_step, prod;
    logic [WIDTH-1:0]   quo, rem, fin_hi, fin_lo;

    always_comb begin
        mul_sum   = {1'b0, work_reg[2*WIDTH-1:WIDTH]} + (work_reg[0] ? {1'b0, bmag_reg} : '0);
        mul_step  = {mul_sum, work_reg[WIDTH-1:1]};
        div_shift = {work_reg[2*WIDTH-1:WIDTH], work_reg[WIDTH-1]};
        div_diff  = div_shift - {1'b0, bmag_reg};
        div_ge    = div_shift >= {1'b0, bmag_reg};
        div_step  = {div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0],
                     work_reg[WIDTH-2:0], div_ge};
        work_step = is_div_reg ? div_step : mul_step;

        prod = neg_q_reg ? -work_step : work_step;
        quo  = work_step[WIDTH-1:0];
        rem  = work_step[2*WIDTH-1:WIDTH];
        if (is_div_reg) begin
            fin_lo = div_zero_reg ? '1 : (neg_q_reg ? -quo : quo);
            fin_hi = neg_r_reg ? -rem : rem;
        end else begin
            fin_lo = prod[WIDTH-1:0];
            fin_hi = prod[2*WIDTH-1:WIDTH];
        end
    end

    always_comb begin
        state_next    = state_reg;
        count_next    = count_reg;
        work_next     = work_reg;
        bmag_next     = bmag_reg;
        is_div_next   = is_div_reg;
        neg_q_next    = neg_q_reg;
        neg_r_next    = neg_r_reg;
        div_zero_next = div_zero_reg;
        hi_next       = hi_reg;
        lo_next       = lo_reg;
        case (state_reg)
            IDLE: begin
                if (is_md) begin
                    state_next    = BUSY;
                    count_next    = CW'(WIDTH);
                    work_next     = {{WIDTH{1'b0}}, amag};
                    bmag_next     = bmag;
                    is_div_next   = alucontrol_exe[2];
                    neg_q_next    = sign_a ^ sign_b;
                    neg_r_next    = sign_a;
                    div_zero_next = (src_b == '0);
                end
            end
            BUSY: begin
                work_next  = work_step;
                count_next = count_reg - 1'b1;
                if (count_reg == CW'(1)) begin
                    state_next = DONE;
                    hi_next    = fin_hi;
                    lo_next    = fin_lo;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            count_reg    <= '0;
            work_reg     <= '0;
            bmag_reg     <= '0;
            is_div_reg   <= 1'b0;
            neg_q_reg    <= 1'b0;
            neg_r_reg    <= 1'b0;
            div_zero_reg <= 1'b0;
            hi_reg       <= '0;
            lo_reg       <= '0;
        end else begin
            state_reg    <= state_next;
            count_reg    <= count_next;
            work_reg     <= work_next;
            bmag_reg     <= bmag_next;
            is_div_reg   <= is_div_next;
            neg_q_reg    <= neg_q_next;
            neg_r_reg    <= neg_r_next;
            div_zero_reg <= div_zero_next;
            hi_reg       <= hi_next;
            lo_reg       <= lo_next;
        end
    end

    assign stall_md = ((state_reg == IDLE) && is_md) || (state_reg == BUSY);

    // ---------------- ALU ----------------
    always_comb begin
        aluout_exe = '0;
        case (alucontrol_exe)
            OP_AND:  aluout_exe = src_a & src_b;
            OP_OR:   aluout_exe = src_a | src_b;
            OP_ADD:  aluout_exe = src_a + src_b;
            OP_XOR:  aluout_exe = src_a ^ src_b;
            OP_NOR:  aluout_exe = ~(src_a | src_b);
            OP_SUB:  aluout_exe = src_a - src_b;
            OP_SLL:  aluout_exe = fwd_b << sh;
            OP_SRL:  aluout_exe = fwd_b >> sh;
            OP_SRA:  aluout_exe = WIDTH'($signed(fwd_b) >>> sh);
            OP_SLT:  aluout_exe = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            OP_MFHI: aluout_exe = hi_reg;
            OP_MFLO: aluout_exe = lo_reg;
            default: aluout_exe = '0;
        endcase
    end

    assign writedata_exe = fwd_b;
    assign writereg_exe  = regdst_exe ? Rd_exe : Rt_exe;
    assign regwrite_out  = regwrite_exe;
    assign memtoreg_out  = memtoreg_exe;
    assign memwrite_out  = memwrite_exe;

endmodule
